// File: rtl/clock_gearbox_pkg.sv
// clock_gearbox shared constants
// default parameters and channel limits
package clock_gearbox_pkg;

  localparam int CG_MAX_CH      = 8;
  localparam int CG_DIV_W       = 16;
  localparam int CG_DEFAULT_DIV = 0;
  localparam int CG_RST_CYCLES  = 65535;
  localparam int CG_DEB_CYCLES  = 1000;
  localparam int CG_RST_W       = 20;

endpackage

// File: rtl/clock_gearbox_ce_divider.sv
// ce_divider: one clock-enable channel
// holds div/cnt, emits registered ce pulse
module ce_divider #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             step_mode,
  input  logic             step_pulse,
  input  logic             step_exit,
  output logic             ce
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;

  // divide counter; load and step control override free-running count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div <= DIV_RST;
      cnt <= '0;
      ce  <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (load) begin
      div <= load_val;
      cnt <= '0;
      ce  <= 1'b0;
    end else if (step_mode) begin
      ce  <= step_pulse;
    end else if (step_exit) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (cnt == div) begin
      cnt <= '0;
      ce  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_gearbox.sv
// clock_gearbox: reset sequencer + N_CH ce dividers
// optional single-step via CLOCK_GEARBOX_STEP_EN
module clock_gearbox
  import clock_gearbox_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = CG_DIV_W,
  parameter int DEFAULT_DIV = CG_DEFAULT_DIV,
  parameter int RST_CYCLES  = CG_RST_CYCLES,
  parameter int DEB_CYCLES  = CG_DEB_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             resetn,
  output logic [N_CH-1:0]  ce,
  input  logic             div_load,
  input  logic [2:0]       div_ch,
  input  logic [DIV_W-1:0] div_val,
  input  logic             step_mode,
  input  logic             step_btn
);

  if (N_CH < 1 || N_CH > CG_MAX_CH) begin : g_bad_nch
    $error("clock_gearbox: N_CH out of range");
  end
  if (RST_CYCLES < 1 || RST_CYCLES >= (1 << CG_RST_W)) begin : g_bad_rst
    $error("clock_gearbox: RST_CYCLES out of range");
  end

  localparam logic [CG_RST_W-1:0] RST_END = CG_RST_W'(RST_CYCLES);
  localparam logic [3:0] NCH_L = 4'(N_CH);

  logic [CG_RST_W-1:0] rst_cnt;
  logic ch_ok;
  logic step_on;
  logic step_pulse;
  logic step_exit;

  // reset sequencer: count up after RESET, saturate at RST_END
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rst_cnt <= '0;
    end else if (rst_cnt != RST_END) begin
      rst_cnt <= rst_cnt + 1'b1;
    end
  end

  assign resetn = (rst_cnt == RST_END);
  assign ch_ok  = ({1'b0, div_ch} < NCH_L);

`ifdef CLOCK_GEARBOX_STEP_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_END = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       btn_sync;
  logic             deb;
  logic             deb_q;
  logic             mode_q;
  logic [DEB_W-1:0] deb_cnt;

  // button sync + debounce; level accepted after DEB_CYCLES stable
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_sync <= '0;
      deb      <= 1'b0;
      deb_q    <= 1'b0;
      deb_cnt  <= '0;
      mode_q   <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], step_btn};
      deb_q    <= deb;
      mode_q   <= step_mode;
      if (btn_sync[1] == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_END) begin
        deb     <= btn_sync[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign step_on    = step_mode;
  assign step_pulse = deb & ~deb_q;
  assign step_exit  = mode_q & ~step_mode;
`else
  logic        unused_step;
  logic [31:0] unused_deb;

  assign unused_step = &{1'b0, step_mode, step_btn};
  assign unused_deb  = 32'(DEB_CYCLES);
  assign step_on     = 1'b0;
  assign step_pulse  = 1'b0;
  assign step_exit   = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ld;
    assign ld = div_load && ch_ok && (div_ch == 3'(i));

    ce_divider #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_div (
      .CLK       (CLK),
      .RESET     (RESET),
      .run       (resetn),
      .load      (ld),
      .load_val  (div_val),
      .step_mode (step_on),
      .step_pulse(step_pulse),
      .step_exit (step_exit),
      .ce        (ce[i])
    );
  end

endmodule

// File: tb/tb_clock_gearbox.sv
// tb_clock_gearbox: table, sequence and random checks
// against a cycle-index arithmetic reference model
module tb_clock_gearbox;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int RST  = 20;
  localparam int DEFD = 2;
  localparam int DEB  = 4;
`ifdef CLOCK_GEARBOX_STEP_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          resetn;
  logic [N-1:0]  ce;
  logic          div_load;
  logic [2:0]    div_ch;
  logic [DW-1:0] div_val;
  logic          step_mode;
  logic          step_btn;

  always #5 CLK = ~CLK;

  clock_gearbox #(
    .N_CH       (N),
    .DIV_W      (DW),
    .DEFAULT_DIV(DEFD),
    .RST_CYCLES (RST),
    .DEB_CYCLES (DEB)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .resetn   (resetn),
    .ce       (ce),
    .div_load (div_load),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .step_mode(step_mode),
    .step_btn (step_btn)
  );

  int errors = 0;
  int checks = 0;
  int t = 0;
  int last_rst = 0;
  int anchor[N];
  int mdiv[N];
  bit prev_sm = 1'b0;
  bit chk_en = 1'b0;
  logic rn_s;
  logic [N-1:0] ce_s;

  typedef struct {
    int d0;
    int d1;
    int n;
    int e0;
    int e1;
  } vec_t;

  vec_t vecs[5];

  // resetn rises RST cycles after the first RESET=0 cycle
  function automatic bit exp_rn(int tt);
    return tt >= last_rst + 1 + RST;
  endfunction

  // pulses land every div+1 cycles after the channel's zero point
  function automatic bit exp_ce(int i, int tt);
    if (!exp_rn(tt)) return 1'b0;
    if (tt <= anchor[i]) return 1'b0;
    return ((tt - anchor[i]) % (mdiv[i] + 1)) == 0;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d want %0d", name, t, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit ld, input int ch,
                     input int v, input bit sm, input bit sb);
    logic [N-1:0] ex;
    @(negedge CLK);
    RESET     = rst;
    div_load  = ld;
    div_ch    = 3'(ch);
    div_val   = DW'(v);
    step_mode = sm;
    step_btn  = sb;
    rn_s = resetn;
    ce_s = ce;
    if (chk_en) begin
      check("resetn", int'(resetn), int'(exp_rn(t)));
      if (!(STEP && prev_sm)) begin
        for (int i = 0; i < N; i++) ex[i] = exp_ce(i, t);
        check("ce", int'(ce), int'(ex));
      end
    end
    chk_en = 1'b1;
    if (rst) begin
      last_rst = t;
      for (int i = 0; i < N; i++) begin
        mdiv[i]   = DEFD;
        anchor[i] = t + 1 + RST;
      end
    end else begin
      if (ld && exp_rn(t) && ch < N) begin
        mdiv[ch]   = v;
        anchor[ch] = t + 1;
      end
      if (STEP && prev_sm && !sm && exp_rn(t))
        for (int i = 0; i < N; i++) anchor[i] = t + 1;
    end
    prev_sm = rst ? 1'b0 : sm;
    t++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_up(input string name);
    int low;
    int bad;
    low = 0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (rn_s) break;
      low++;
      bad |= int'(|ce_s);
    end
    check(name, low, RST);
    check({name, "_ce"}, bad, 0);
  endtask

  task automatic gap(input string name, input int want);
    int g;
    g = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      g++;
      if (ce_s[0]) break;
    end
    check(name, g, want);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    vecs[0] = '{3, 0, 12, 3, 11};
    vecs[1] = '{5, 1, 13, 2, 6};
    vecs[2] = '{0, 3, 9, 9, 2};
    vecs[3] = '{1, 2, 7, 3, 2};
    vecs[4] = '{4, 4, 10, 2, 1};
    RESET = 1'b1;
    div_load = 1'b0;
    div_ch = '0;
    div_val = '0;
    step_mode = 1'b0;
    step_btn = 1'b0;
    for (int i = 0; i < N; i++) begin
      mdiv[i] = DEFD;
      anchor[i] = 0;
    end

    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    wait_up("rst_len");
    gap("first_ce_default", DEFD + 1);
    idle(20);

    for (int v = 0; v < 5; v++) begin
      cyc(0, 1, 0, vecs[v].d0, 0, 0);
      cyc(0, 1, 1, vecs[v].d1, 0, 0);
      c0 = 0;
      c1 = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        cyc(0, 0, 0, 0, 0, 0);
        c0 += int'(ce_s[0]);
        c1 += int'(ce_s[1]);
      end
      check($sformatf("vec%0d_ce0", v), c0, vecs[v].e0);
      check($sformatf("vec%0d_ce1", v), c1, vecs[v].e1);
    end

    cyc(0, 1, 0, 3, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("load_cycle_ce0", int'(ce_s[0]), 0);
    gap("reload_first", 6);
    gap("reload_period", 6);
    cyc(0, 1, 7, 1, 0, 0);
    idle(14);

    cyc(1, 0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, 0, 0, 0);
    wait_up("restart_len");
    gap("restart_default", DEFD + 1);

    for (int k = 0; k < 700; k++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, 9)),
          STEP ? 1'b0 : 1'($urandom_range(0, 1)),
          STEP ? 1'b0 : 1'($urandom_range(0, 1)));
    end

`ifdef CLOCK_GEARBOX_STEP_EN
    begin
      int ones;
      int other;
      cyc(1, 0, 0, 0, 0, 0);
      wait_up("step_rst_len");
      cyc(0, 1, 0, 1, 0, 0);
      idle(5);
      repeat (3) cyc(0, 0, 0, 0, 1, 0);
      ones = 0;
      other = 0;
      for (int k = 0; k < 23; k++) begin
        cyc(0, 0, 0, 0, 1, k < 3);
        ones  += int'(ce_s == '1);
        other += int'(ce_s != '0 && ce_s != '1);
      end
      check("glitch_ones", ones, 0);
      check("glitch_other", other, 0);
      ones = 0;
      other = 0;
      for (int k = 0; k < 30; k++) begin
        cyc(0, 0, 0, 0, 1, k < 10);
        ones  += int'(ce_s == '1);
        other += int'(ce_s != '0 && ce_s != '1);
      end
      check("press_ones", ones, 1);
      check("press_other", other, 0);
      idle(20);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
